// File: rtl/shift_reg_out_pkg.sv
// Shared sizing for the spike-word IO path: default widths and the
// beat-count derivation used by both the output serializer and the input deserializer.
package shift_reg_out_pkg;

    localparam int WORD_WIDTH_DEF = 16;
    localparam int IO_WIDTH_DEF   = 8;

    function automatic int nbeats_f(input int word_w, input int io_w);
        return word_w / io_w;
    endfunction

    // A single-beat word still needs a 1-bit counter so the port widths stay legal
    function automatic int cnt_width_f(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_out_if.sv
// Core-side word handshake plus pin-side beat handshake of the spike serializer.
// slave = serializer view, master = core/pin-driver view.
interface shift_reg_out_if
    import shift_reg_out_pkg::*;
#(
    parameter int IO_WIDTH   = IO_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
);
    logic                  IN_VALID_INTERNAL;
    logic [WORD_WIDTH-1:0] IN_SPIKE_INTERNAL;
    logic                  BP_INTERNAL;
    logic                  OUT_VALID;
    logic [IO_WIDTH-1:0]   OUT_SPIKE;
    logic                  BP;
    logic                  BUSY;

    modport master (
        output IN_VALID_INTERNAL, IN_SPIKE_INTERNAL, BP,
        input  BP_INTERNAL, OUT_VALID, OUT_SPIKE, BUSY
    );

    modport slave (
        input  IN_VALID_INTERNAL, IN_SPIKE_INTERNAL, BP,
        output BP_INTERNAL, OUT_VALID, OUT_SPIKE, BUSY
    );
endinterface

// File: rtl/shift_reg_out_skid.sv
// One-entry spike-word skid buffer: parks a word accepted while the shift register
// is still busy. Push and pop never coincide (push requires the entry to be empty).
module shift_reg_out_skid #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic                  vld_o,
    output logic [WORD_WIDTH-1:0] data_o
);
    logic                  vld_q, vld_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (push_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (pop_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

// File: rtl/shift_reg_out.sv
// Spike-word serializer: sends each WORD_WIDTH word as NBEATS IO_WIDTH beats, LSB
// slice first, with a one-word skid so back-to-back words leave without bubbles.
module shift_reg_out
    import shift_reg_out_pkg::*;
#(
    parameter int IO_WIDTH   = IO_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    shift_reg_out_if.slave bus
);
    localparam int NBEATS    = nbeats_f(WORD_WIDTH, IO_WIDTH);
    localparam int CNT_WIDTH = cnt_width_f(NBEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NBEATS - 1);

    logic [WORD_WIDTH-1:0] shift_data_q, shift_data_d;
    logic                  shift_vld_q, shift_vld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  hold_vld;
    logic [WORD_WIDTH-1:0] hold_data;

    logic xfer, last, acc, load_slot, hold_push, hold_pop;

    assign xfer      = shift_vld_q & ~bus.BP;
    assign last      = xfer & (cnt_q == LAST_CNT);
    assign acc       = bus.IN_VALID_INTERNAL & ~hold_vld;
    assign load_slot = ~shift_vld_q | last;
    // A parked word always wins the shift slot; the core only gets it when the skid is empty
    assign hold_pop  = load_slot & hold_vld;
    assign hold_push = acc & ~load_slot;

    always_comb begin
        shift_data_d = shift_data_q;
        shift_vld_d  = shift_vld_q;
        cnt_d        = cnt_q;
        if (load_slot) begin
            if (hold_vld) begin
                shift_data_d = hold_data;
                shift_vld_d  = 1'b1;
                cnt_d        = '0;
            end else if (acc) begin
                shift_data_d = bus.IN_SPIKE_INTERNAL;
                shift_vld_d  = 1'b1;
                cnt_d        = '0;
            end else begin
                shift_vld_d  = 1'b0;
            end
        end else if (xfer) begin
            shift_data_d = shift_data_q >> IO_WIDTH;
            cnt_d        = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_data_q <= '0;
            shift_vld_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            shift_data_q <= shift_data_d;
            shift_vld_q  <= shift_vld_d;
            cnt_q        <= cnt_d;
        end
    end

    shift_reg_out_skid #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_skid (
        .CLK   (CLK),
        .RST   (RST),
        .push_i(hold_push),
        .pop_i (hold_pop),
        .data_i(bus.IN_SPIKE_INTERNAL),
        .vld_o (hold_vld),
        .data_o(hold_data)
    );

    assign bus.OUT_VALID   = shift_vld_q;
    assign bus.OUT_SPIKE   = shift_data_q[IO_WIDTH-1:0];
    assign bus.BP_INTERNAL = hold_vld;
    assign bus.BUSY        = shift_vld_q | hold_vld;
endmodule

// File: tb/tb_shift_reg_out.sv
// Bench for the spike serializer: directed cycle table, mid-word reset, and a random
// loopback run at 8-bit and 16-bit pin widths against a word-queue reference.
module tb_shift_reg_out;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    shift_reg_out_if #(.IO_WIDTH(8),  .WORD_WIDTH(16)) b8 ();
    shift_reg_out_if #(.IO_WIDTH(16), .WORD_WIDTH(16)) b16 ();

    shift_reg_out #(.IO_WIDTH(8),  .WORD_WIDTH(16)) dut8  (.CLK(CLK), .RST(RST), .bus(b8.slave));
    shift_reg_out #(.IO_WIDTH(16), .WORD_WIDTH(16)) dut16 (.CLK(CLK), .RST(RST), .bus(b16.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        bp;
        logic        ov;
        logic [7:0]  sp;
        logic        bpi;
        logic        busy;
    } vec_t;

    function automatic vec_t v(input logic iv, input logic [15:0] d, input logic bp,
                               input logic ov, input logic [7:0] sp, input logic bpi,
                               input logic busy);
        vec_t r;
        r.iv = iv; r.d = d; r.bp = bp; r.ov = ov; r.sp = sp; r.bpi = bpi; r.busy = busy;
        return r;
    endfunction

    vec_t tbl[25];

    logic [15:0] q8[$];
    logic [15:0] q16[$];

    initial begin
        logic [15:0] rb8;
        logic [15:0] w8, w16;
        int idx8, done8, done16, acc8, acc16, cyc;

        // each row: inputs held this cycle, outputs expected before the next edge
        tbl[0]  = v(1, 16'hA55A, 0,  0, 8'h00, 0, 0);
        tbl[1]  = v(0, 16'h0000, 0,  1, 8'h5A, 0, 1);
        tbl[2]  = v(0, 16'h0000, 0,  1, 8'hA5, 0, 1);
        tbl[3]  = v(0, 16'h0000, 0,  0, 8'h00, 0, 0);
        tbl[4]  = v(1, 16'hBEEF, 0,  0, 8'h00, 0, 0);
        tbl[5]  = v(1, 16'h1111, 1,  1, 8'hEF, 0, 1);
        tbl[6]  = v(1, 16'h2222, 1,  1, 8'hEF, 1, 1);
        tbl[7]  = v(1, 16'h2222, 1,  1, 8'hEF, 1, 1);
        tbl[8]  = v(1, 16'h2222, 1,  1, 8'hEF, 1, 1);
        tbl[9]  = v(1, 16'h2222, 1,  1, 8'hEF, 1, 1);
        tbl[10] = v(1, 16'h2222, 0,  1, 8'hEF, 1, 1);
        tbl[11] = v(1, 16'h2222, 0,  1, 8'hBE, 1, 1);
        tbl[12] = v(1, 16'h2222, 0,  1, 8'h11, 0, 1);
        tbl[13] = v(0, 16'h0000, 0,  1, 8'h11, 1, 1);
        tbl[14] = v(0, 16'h0000, 0,  1, 8'h22, 0, 1);
        tbl[15] = v(0, 16'h0000, 0,  1, 8'h22, 0, 1);
        tbl[16] = v(0, 16'h0000, 0,  0, 8'h00, 0, 0);
        tbl[17] = v(1, 16'h1234, 0,  0, 8'h00, 0, 0);
        tbl[18] = v(1, 16'h5678, 0,  1, 8'h34, 0, 1);
        tbl[19] = v(1, 16'h9ABC, 0,  1, 8'h12, 1, 1);
        tbl[20] = v(1, 16'h9ABC, 0,  1, 8'h78, 0, 1);
        tbl[21] = v(0, 16'h0000, 0,  1, 8'h56, 1, 1);
        tbl[22] = v(0, 16'h0000, 0,  1, 8'hBC, 0, 1);
        tbl[23] = v(0, 16'h0000, 0,  1, 8'h9A, 0, 1);
        tbl[24] = v(0, 16'h0000, 0,  0, 8'h00, 0, 0);

        b8.IN_VALID_INTERNAL  = 1'b0; b8.IN_SPIKE_INTERNAL  = '0; b8.BP  = 1'b0;
        b16.IN_VALID_INTERNAL = 1'b0; b16.IN_SPIKE_INTERNAL = '0; b16.BP = 1'b0;

        #1 RST = 1'b1;
        #2;
        chk("rst_ovld",  {15'd0, b8.OUT_VALID},   16'd0);
        chk("rst_spike", {8'd0,  b8.OUT_SPIKE},   16'd0);
        chk("rst_bpi",   {15'd0, b8.BP_INTERNAL}, 16'd0);
        chk("rst_busy",  {15'd0, b8.BUSY},        16'd0);
        chk("rst16_busy", {15'd0, b16.BUSY},      16'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            b8.IN_VALID_INTERNAL = tbl[i].iv;
            b8.IN_SPIKE_INTERNAL = tbl[i].d;
            b8.BP                = tbl[i].bp;
            #1;
            chk($sformatf("tbl%0d_ovld", i), {15'd0, b8.OUT_VALID}, {15'd0, tbl[i].ov});
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_spike", i), {8'd0, b8.OUT_SPIKE}, {8'd0, tbl[i].sp});
            chk($sformatf("tbl%0d_bpi", i),  {15'd0, b8.BP_INTERNAL}, {15'd0, tbl[i].bpi});
            chk($sformatf("tbl%0d_busy", i), {15'd0, b8.BUSY},        {15'd0, tbl[i].busy});
        end

        // mid-word reset with a second word parked in the skid
        @(negedge CLK);
        b8.IN_VALID_INTERNAL = 1'b1; b8.IN_SPIKE_INTERNAL = 16'hA55A; b8.BP = 1'b0;
        @(negedge CLK);
        b8.IN_VALID_INTERNAL = 1'b1; b8.IN_SPIKE_INTERNAL = 16'h0F0F; b8.BP = 1'b0;
        #1 chk("mrst_beat0", {8'd0, b8.OUT_SPIKE}, 16'h005A);
        @(negedge CLK);
        b8.IN_VALID_INTERNAL = 1'b0; b8.BP = 1'b1;
        #1;
        chk("mrst_beat1",   {8'd0, b8.OUT_SPIKE},   16'h00A5);
        chk("mrst_holdbpi", {15'd0, b8.BP_INTERNAL}, 16'd1);
        #1 RST = 1'b1;
        #1;
        chk("mrst_ovld", {15'd0, b8.OUT_VALID},   16'd0);
        chk("mrst_bpi",  {15'd0, b8.BP_INTERNAL}, 16'd0);
        chk("mrst_busy", {15'd0, b8.BUSY},        16'd0);
        @(negedge CLK);
        RST = 1'b0; b8.BP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("post_rst%0d_ovld", i), {15'd0, b8.OUT_VALID}, 16'd0);
            chk($sformatf("post_rst%0d_busy", i), {15'd0, b8.BUSY},      16'd0);
        end

        // random loopback: each DUT's beats are reassembled and compared to accepted words
        idx8 = 0; rb8 = '0; done8 = 0; done16 = 0; acc8 = 0; acc16 = 0; cyc = 0;
        while ((done8 < 1000 || done16 < 1000) && cyc < 40000) begin
            @(negedge CLK);
            cyc++;
            w8  = 16'($urandom);
            w16 = 16'($urandom);
            b8.IN_VALID_INTERNAL  = ($urandom_range(0, 9) < 7) && (acc8 < 1000);
            b8.IN_SPIKE_INTERNAL  = w8;
            b8.BP                 = ($urandom_range(0, 9) < 3);
            b16.IN_VALID_INTERNAL = ($urandom_range(0, 9) < 7) && (acc16 < 1000);
            b16.IN_SPIKE_INTERNAL = w16;
            b16.BP                = ($urandom_range(0, 9) < 3);
            #1;

            chk("r8_ovld", {15'd0, b8.OUT_VALID},   {15'd0, q8.size() > 0});
            chk("r8_busy", {15'd0, b8.BUSY},        {15'd0, q8.size() > 0});
            chk("r8_bpi",  {15'd0, b8.BP_INTERNAL}, {15'd0, q8.size() == 2});
            if (b8.OUT_VALID && !b8.BP) begin
                rb8[idx8*8 +: 8] = b8.OUT_SPIKE;
                idx8++;
                if (idx8 == 2) begin
                    if (q8.size() > 0) begin
                        chk("r8_word", rb8, q8[0]);
                        void'(q8.pop_front());
                    end else begin
                        chk("r8_extra_word", 16'd1, 16'd0);
                    end
                    idx8 = 0;
                    done8++;
                end
            end
            if (b8.IN_VALID_INTERNAL && !b8.BP_INTERNAL) begin
                q8.push_back(w8);
                acc8++;
            end

            chk("r16_ovld", {15'd0, b16.OUT_VALID},   {15'd0, q16.size() > 0});
            chk("r16_busy", {15'd0, b16.BUSY},        {15'd0, q16.size() > 0});
            chk("r16_bpi",  {15'd0, b16.BP_INTERNAL}, {15'd0, q16.size() == 2});
            if (b16.OUT_VALID && !b16.BP) begin
                if (q16.size() > 0) begin
                    chk("r16_word", b16.OUT_SPIKE, q16[0]);
                    void'(q16.pop_front());
                end else begin
                    chk("r16_extra_word", 16'd1, 16'd0);
                end
                done16++;
            end
            if (b16.IN_VALID_INTERNAL && !b16.BP_INTERNAL) begin
                q16.push_back(w16);
                acc16++;
            end
        end
        chk("r8_words_done",  16'(done8),  16'd1000);
        chk("r16_words_done", 16'(done16), 16'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
